// File: rtl/ysyx_22040729_id_stage.sv
// ysyx_22040729_id_stage: registered RV64I decode stage with a 2-entry skid buffer (rev 1.0).
// Optional M-extension decode is enabled by defining YSYX_22040729_RV64M_EN.
`default_nettype none

module ysyx_22040729_id_stage #(
  parameter int INST_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  input  logic [INST_WIDTH-1:0] in_inst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [4:0]            rd,
  output logic                  rf_we,
  output logic [1:0]            rf_wdata_src,
  output logic [1:0]            npc_src,
  output logic [4:0]            alu_op,
  output logic                  alu_len_dw,
  output logic                  alu_src1_pc,
  output logic                  alu_src2_ri,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [1:0]            mem_size,
  output logic                  mem_unsigned,
  output logic [2:0]            br_cond,
  output logic [DATA_WIDTH-1:0] immediate,
  output logic                  illegal,
  output logic                  ebreak
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [4:0]            rs1, rs2, rd;
    logic                  rf_we;
    logic [1:0]            rf_wdata_src;
    logic [1:0]            npc_src;
    logic [4:0]            alu_op;
    logic                  alu_len_dw, alu_src1_pc, alu_src2_ri;
    logic                  mem_ren, mem_wen;
    logic [1:0]            mem_size;
    logic                  mem_unsigned;
    logic [2:0]            br_cond;
    logic [DATA_WIDTH-1:0] immediate;
    logic                  illegal, ebreak;
  } bundle_t;

  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
                         OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
                         OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OPIMM32 = 7'b0011011,
                         OPC_OP = 7'b0110011, OPC_OP32 = 7'b0111011, OPC_SYSTEM = 7'b1110011,
                         OPC_FENCE = 7'b0001111;
  localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_SLL = 5'd2, ALU_SLT = 5'd3,
                         ALU_SLTU = 5'd4, ALU_XOR = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7,
                         ALU_OR = 5'd8, ALU_AND = 5'd9;

  function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [31:0] inst;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  bundle_t dec;
  logic    ill;

  assign inst  = in_inst[31:0];
  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign imm_i = {{(DATA_WIDTH-12){inst[31]}}, inst[31:20]};
  assign imm_s = {{(DATA_WIDTH-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{(DATA_WIDTH-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {{(DATA_WIDTH-32){inst[31]}}, inst[31:12], 12'b0};
  assign imm_j = {{(DATA_WIDTH-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    dec     = '0;
    ill     = 1'b0;
    dec.pc  = in_pc;
    dec.rs1 = inst[19:15];
    dec.rs2 = inst[24:20];
    dec.rd  = inst[11:7];
    case (opc)
      OPC_LUI: begin
        dec.rf_we = 1'b1; dec.rf_wdata_src = 2'b10; dec.immediate = imm_u;
      end
      OPC_AUIPC: begin
        dec.rf_we = 1'b1; dec.alu_src1_pc = 1'b1; dec.alu_src2_ri = 1'b1; dec.immediate = imm_u;
      end
      OPC_JAL: begin
        dec.rf_we = 1'b1; dec.rf_wdata_src = 2'b11; dec.npc_src = 2'b01; dec.immediate = imm_j;
      end
      OPC_JALR: begin
        dec.rf_we = 1'b1; dec.rf_wdata_src = 2'b11; dec.npc_src = 2'b10; dec.immediate = imm_i;
      end
      OPC_BRANCH: begin
        dec.npc_src = 2'b11; dec.br_cond = f3; dec.immediate = imm_b;
        ill = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LOAD: begin
        dec.rf_we = 1'b1; dec.rf_wdata_src = 2'b01; dec.mem_ren = 1'b1; dec.alu_src2_ri = 1'b1;
        dec.mem_size = f3[1:0]; dec.mem_unsigned = f3[2]; dec.immediate = imm_i;
        ill = (f3 == 3'b111);
      end
      OPC_STORE: begin
        dec.mem_wen = 1'b1; dec.alu_src2_ri = 1'b1; dec.mem_size = f3[1:0]; dec.immediate = imm_s;
        ill = f3[2];
      end
      OPC_OPIMM: begin
        dec.rf_we = 1'b1; dec.alu_src2_ri = 1'b1; dec.immediate = imm_i;
        dec.alu_op = alu_from_f3(f3, (f3 == 3'b101) && inst[30]);
      end
      OPC_OPIMM32: begin
        dec.rf_we = 1'b1; dec.alu_src2_ri = 1'b1; dec.alu_len_dw = 1'b1; dec.immediate = imm_i;
        dec.alu_op = alu_from_f3(f3, (f3 == 3'b101) && inst[30]);
        // only ADDIW/SLLIW/SRLIW/SRAIW exist, and W shifts take a 5-bit shamt
        ill = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101) || (f3 != 3'b000 && inst[25]);
      end
      OPC_OP, OPC_OP32: begin
        dec.rf_we = 1'b1; dec.alu_len_dw = (opc == OPC_OP32);
        if (f7 == 7'b0000000) begin
          dec.alu_op = alu_from_f3(f3, 1'b0);
          ill = (opc == OPC_OP32) && !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101);
        end else if (f7 == 7'b0100000) begin
          dec.alu_op = alu_from_f3(f3, 1'b1);
          ill = !(f3 == 3'b000 || f3 == 3'b101);
        end else if (f7 == 7'b0000001) begin
`ifdef YSYX_22040729_RV64M_EN
          dec.alu_op = {2'b10, f3};
          ill = (opc == OPC_OP32) && (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011);
`else
          ill = 1'b1;
`endif
        end else begin
          ill = 1'b1;
        end
      end
      OPC_SYSTEM: begin
        dec.ebreak = (inst == 32'h0010_0073);
        ill = !dec.ebreak;
      end
      OPC_FENCE: ;
      default: ill = 1'b1;
    endcase
    dec.illegal = ill;
    if (ill) begin
      dec.rf_we = 1'b0; dec.mem_wen = 1'b0; dec.mem_ren = 1'b0; dec.npc_src = 2'b00;
    end
  end

  bundle_t or_q, sk_q;
  logic    or_valid, sk_valid;
  logic    accept, drain;

  assign in_ready = !sk_valid;
  assign accept   = in_valid && in_ready;
  assign drain    = or_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_valid <= 1'b0;
      sk_valid <= 1'b0;
      or_q     <= '0;
      sk_q     <= '0;
    end else if (flush) begin
      or_valid <= 1'b0;
      sk_valid <= 1'b0;
    end else if (!or_valid || drain) begin
      // sk_valid implies in_ready=0, so a skid refill and a new accept never collide
      if (sk_valid) begin
        or_q     <= sk_q;
        or_valid <= 1'b1;
        sk_valid <= 1'b0;
      end else if (accept) begin
        or_q     <= dec;
        or_valid <= 1'b1;
      end else begin
        or_valid <= 1'b0;
      end
    end else if (accept) begin
      sk_q     <= dec;
      sk_valid <= 1'b1;
    end
  end

  assign out_valid    = or_valid;
  assign out_pc       = or_q.pc;
  assign rs1          = or_q.rs1;
  assign rs2          = or_q.rs2;
  assign rd           = or_q.rd;
  assign rf_we        = or_q.rf_we;
  assign rf_wdata_src = or_q.rf_wdata_src;
  assign npc_src      = or_q.npc_src;
  assign alu_op       = or_q.alu_op;
  assign alu_len_dw   = or_q.alu_len_dw;
  assign alu_src1_pc  = or_q.alu_src1_pc;
  assign alu_src2_ri  = or_q.alu_src2_ri;
  assign mem_ren      = or_q.mem_ren;
  assign mem_wen      = or_q.mem_wen;
  assign mem_size     = or_q.mem_size;
  assign mem_unsigned = or_q.mem_unsigned;
  assign br_cond      = or_q.br_cond;
  assign immediate    = or_q.immediate;
  assign illegal      = or_q.illegal;
  assign ebreak       = or_q.ebreak;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040729_id_stage.sv
// Directed bench for ysyx_22040729_id_stage: decode vectors, backpressure, flush and async reset.
`default_nettype none

module tb_ysyx_22040729_id_stage;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [63:0] in_pc, out_pc, immediate;
  logic [31:0] in_inst;
  logic [4:0]  rs1, rs2, rd, alu_op;
  logic [1:0]  rf_wdata_src, npc_src, mem_size;
  logic [2:0]  br_cond;
  logic        rf_we, alu_len_dw, alu_src1_pc, alu_src2_ri, mem_ren, mem_wen, mem_unsigned;
  logic        illegal, ebreak;
  int          checks = 0;
  int          errors = 0;

  ysyx_22040729_id_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .rs1(rs1), .rs2(rs2), .rd(rd), .rf_we(rf_we), .rf_wdata_src(rf_wdata_src),
    .npc_src(npc_src), .alu_op(alu_op), .alu_len_dw(alu_len_dw),
    .alu_src1_pc(alu_src1_pc), .alu_src2_ri(alu_src2_ri),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .br_cond(br_cond), .immediate(immediate), .illegal(illegal), .ebreak(ebreak)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] pc, input logic [31:0] inst);
    in_valid = 1'b1; in_pc = pc; in_inst = inst;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_inst = '0;
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_immediate", immediate, 64'd0);
    chk("rst_rf_we", {63'd0, rf_we}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // addi x1,x0,-1
    send(64'h8000_0000, 32'hFFF0_0093);
    chk("addi_valid", {63'd0, out_valid}, 64'd1);
    chk("addi_pc", out_pc, 64'h8000_0000);
    chk("addi_rd", {59'd0, rd}, 64'd1);
    chk("addi_rs1", {59'd0, rs1}, 64'd0);
    chk("addi_alu_op", {59'd0, alu_op}, 64'd0);
    chk("addi_src2_ri", {63'd0, alu_src2_ri}, 64'd1);
    chk("addi_rf_we", {63'd0, rf_we}, 64'd1);
    chk("addi_imm", immediate, 64'hFFFF_FFFF_FFFF_FFFF);

    // sd x2,8(x1)
    send(64'h8000_0004, 32'h0020_B423);
    chk("sd_mem_wen", {63'd0, mem_wen}, 64'd1);
    chk("sd_mem_size", {62'd0, mem_size}, 64'd3);
    chk("sd_rf_we", {63'd0, rf_we}, 64'd0);
    chk("sd_rs1", {59'd0, rs1}, 64'd1);
    chk("sd_rs2", {59'd0, rs2}, 64'd2);
    chk("sd_imm", immediate, 64'd8);

    // beq x0,x0,-4
    send(64'h8000_0008, 32'hFE00_0EE3);
    chk("beq_npc_src", {62'd0, npc_src}, 64'd3);
    chk("beq_br_cond", {61'd0, br_cond}, 64'd0);
    chk("beq_imm", immediate, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_rf_we", {63'd0, rf_we}, 64'd0);

    // lwu x5,0(x1)
    send(64'h8000_000C, 32'h0000_E283);
    chk("lwu_mem_ren", {63'd0, mem_ren}, 64'd1);
    chk("lwu_mem_size", {62'd0, mem_size}, 64'd2);
    chk("lwu_unsigned", {63'd0, mem_unsigned}, 64'd1);
    chk("lwu_wdata_src", {62'd0, rf_wdata_src}, 64'd1);

    // store with funct3=100 is illegal
    send(64'h8000_0010, 32'h0000_4023);
    chk("badst_illegal", {63'd0, illegal}, 64'd1);
    chk("badst_mem_wen", {63'd0, mem_wen}, 64'd0);

    // sub x3,x1,x2
    send(64'h8000_0014, 32'h4020_81B3);
    chk("sub_alu_op", {59'd0, alu_op}, 64'd1);
    chk("sub_illegal", {63'd0, illegal}, 64'd0);

    // slliw with shamt[5]=1 is illegal
    send(64'h8000_0018, 32'h0200_101B);
    chk("slliw_illegal", {63'd0, illegal}, 64'd1);
    chk("slliw_rf_we", {63'd0, rf_we}, 64'd0);

    // mul x3,x1,x2
    send(64'h8000_001C, 32'h0220_81B3);
`ifdef YSYX_22040729_RV64M_EN
    chk("mul_alu_op", {59'd0, alu_op}, 64'd16);
    chk("mul_rd", {59'd0, rd}, 64'd3);
    chk("mul_illegal", {63'd0, illegal}, 64'd0);
`else
    chk("mul_illegal", {63'd0, illegal}, 64'd1);
    chk("mul_rf_we", {63'd0, rf_we}, 64'd0);
`endif

    send(64'h8000_0020, 32'h0010_0073);
    chk("ebreak_flag", {63'd0, ebreak}, 64'd1);
    chk("ebreak_illegal", {63'd0, illegal}, 64'd0);
    send(64'h8000_0024, 32'h0000_0073);
    chk("ecall_illegal", {63'd0, illegal}, 64'd1);
    chk("ecall_ebreak", {63'd0, ebreak}, 64'd0);
    tick();
    chk("idle_valid", {63'd0, out_valid}, 64'd0);

    // backpressure: three back-to-back instructions while EX stalls
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 64'h100; in_inst = 32'h0000_0093;
    tick();
    chk("bp1_valid", {63'd0, out_valid}, 64'd1);
    chk("bp1_pc", out_pc, 64'h100);
    chk("bp1_in_ready", {63'd0, in_ready}, 64'd1);
    in_pc = 64'h104; in_inst = 32'h0000_0113;
    tick();
    chk("bp2_pc", out_pc, 64'h100);
    chk("bp2_in_ready", {63'd0, in_ready}, 64'd0);
    in_pc = 64'h108; in_inst = 32'h0000_0193;
    tick();
    chk("bp3_in_ready", {63'd0, in_ready}, 64'd0);
    chk("bp3_hold_pc", out_pc, 64'h100);
    chk("bp3_hold_rd", {59'd0, rd}, 64'd1);
    out_ready = 1'b1;
    tick();
    chk("drain1_pc", out_pc, 64'h104);
    chk("drain1_rd", {59'd0, rd}, 64'd2);
    chk("drain1_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    chk("drain2_valid", {63'd0, out_valid}, 64'd1);
    chk("drain2_pc", out_pc, 64'h108);
    tick();
    chk("drain3_valid", {63'd0, out_valid}, 64'd0);

    // flush with both entries full and an instruction offered
    out_ready = 1'b0;
    send(64'h200, 32'h0000_0093);
    send(64'h204, 32'h0000_0113);
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    flush = 1'b1; in_valid = 1'b1; in_pc = 64'h208; in_inst = 32'h0000_0193;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    chk("flush_after_valid", {63'd0, out_valid}, 64'd0);

    // flush dominates an accept into an empty stage
    flush = 1'b1;
    send(64'h300, 32'h0000_0093);
    flush = 1'b0;
    chk("flush_acc_valid", {63'd0, out_valid}, 64'd0);

    // asynchronous reset while stalled
    out_ready = 1'b0;
    send(64'h400, 32'h0000_0093);
    chk("stall_valid", {63'd0, out_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/ysyx_22040729_id_stage.md
Name: ysyx_22040729_id_stage

Overview:
Registered instruction-decode pipeline stage for the RV64 core, between IF and EX.
- Accepts {pc, instruction} from IF over a valid/ready handshake.
- Performs full RV64I decode: ALU op, memory size/sign, branch condition, and illegal-instruction detection.
- Presents a registered control bundle to EX.
- A 2-entry skid buffer sustains 1 instruction/cycle under backpressure; a flush input squashes in-flight work.

Parameters:
INST_WIDTH, 32, instruction width
DATA_WIDTH, 64, immediate/datapath width
ADDR_WIDTH, 64, PC width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  squash all buffered instructions
in_valid  in  1  IF has instruction
in_ready  out  1  stage can accept
in_pc  in  ADDR_WIDTH  instruction PC
in_inst  in  INST_WIDTH  instruction word
out_valid  out  1  decoded bundle valid
out_ready  in  1  EX accepts bundle
out_pc  out  ADDR_WIDTH  PC of bundle
rs1, rs2, rd  out  5 each  register indices
rf_we  out  1  register write enable
rf_wdata_src  out  2  00 ALU, 01 load data, 10 immediate (LUI), 11 pc+4
npc_src  out  2  00 pc+4, 01 pc+imm (JAL), 10 rs1+imm (JALR), 11 conditional branch
alu_op  out  5  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND; 16-23 M-ext
alu_len_dw  out  1  32-bit W-op, sign-extend result
alu_src1_pc  out  1  ALU src1 = pc (AUIPC)
alu_src2_ri  out  1  ALU src2 = immediate
mem_ren, mem_wen  out  1 each  load/store
mem_size  out  2  0 B, 1 H, 2 W, 3 D
mem_unsigned  out  1  zero-extend load
br_cond  out  3  funct3 of branch
immediate  out  DATA_WIDTH  sign-extended I/S/B/U/J immediate
illegal  out  1  undecodable instruction
ebreak  out  1  instruction == 0x00100073

Behaviour:
- Reset (async, rst_n low): both buffer entries invalid; out_valid=0; all bundle outputs 0; in_ready=1.
- Storage: output register (OR) plus skid register (SK). in_ready = !SK.valid (registered-derived, no combinational path from out_ready).
- Accept = in_valid && in_ready. Decode is combinational on in_inst; the result is captured:
  - into OR if OR is empty or draining (out_valid && out_ready) and SK is empty;
  - otherwise into SK.
- On drain with SK full: SK moves into OR and SK clears.
- Latency: 1 cycle accept -> out_valid. Throughput: 1/cycle. Order is strictly FIFO.
- Outputs hold stable while out_valid && !out_ready.
- flush: next cycle OR.valid=0 and SK.valid=0. An accept in the same cycle is dropped. flush dominates drain and accept.
- Immediate formats:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - All sign-extended to DATA_WIDTH. R-type: 0.
- ALU op: from funct3 plus inst[30] (SUB/SRA). RV64 shift-immediate uses a 6-bit shamt. OP-IMM-32/OP-32 set alu_len_dw=1.
- Illegal=1 when any of:
  - opcode is unknown;
  - load funct3=111;
  - store funct3>011;
  - branch funct3 is 010 or 011;
  - R-type funct7 is not 0000000, or 0100000 with ADD/SRL funct3;
  - *W shift-immediate has shamt[5]=1;
  - SYSTEM instruction other than EBREAK.
- When illegal=1: rf_we=mem_wen=mem_ren=0 and npc_src=00.
- Writes with rd=0 still report rf_we=1; the register file ignores them.

Optional Feature:
Macro: YSYX_22040729_RV64M_EN
- Defined: funct7=0000001 on OP/OP-32 decodes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU to alu_op 16-23 by funct3. OP-32 accepts only MULW/DIVW/DIVUW/REMW/REMUW, with alu_len_dw=1.
- Undefined: funct7=0000001 gives illegal=1.

Test Plan:
- After reset release, 0xFFF00093 (addi x1,x0,-1) presented at cycle N -> at N+1: out_valid=1, rd=1, rs1=0, alu_op=0, alu_src2_ri=1, rf_we=1, immediate=0xFFFFFFFFFFFFFFFF.
- 0x0020B423 (sd x2,8(x1)) -> mem_wen=1, mem_size=3, rf_we=0, rs1=1, rs2=2, immediate=8. Then 0xFE000EE3 (beq x0,x0,-4) -> npc_src=11, br_cond=0, immediate=0xFFFFFFFFFFFFFFFC.
- Three back-to-back instructions with out_ready=0 for 3 cycles -> first two accepted, in_ready=0 on the third. After out_ready=1, bundles exit in order on consecutive cycles.
- Both entries full, then flush=1 for one cycle with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed-cycle instruction never appears.
- 0x022081B3 (mul x3,x1,x2) -> with macro: alu_op=16, rd=3, illegal=0. Without macro: illegal=1, rf_we=0.
- 0x00100073 -> ebreak=1, illegal=0. 0x00000073 (ecall) -> illegal=1. Reset asserted mid-stall -> out_valid=0 immediately (async).
